// File: rtl/piso_shift6_pkg.sv
// Shared definitions for the 6-bit serial link: state encoding and default word width.
package piso_shift6_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Word width shared with the receive-side serial-in / parallel-out register.
  localparam int DEF_WIDTH = 6;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } piso_state_e;

endpackage : piso_shift6_pkg

// File: rtl/piso_shift6.sv
// Parallel-in / serial-out transmitter: accepts a word on load&&ready and
// streams it out one bit per clock, back-to-back words with no idle cycle.
module piso_shift6
  import piso_shift6_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             done,
  output logic             busy
);

  localparam int                CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]     LAST    = CW'(WIDTH - 1);
  localparam int                OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             arm_q, arm_d;

  logic             last_s;
  logic             accept_s;
  logic [WIDTH-1:0] shifted_s;

  // arm_q stays low for the first edge after reset release, so a load that
  // coincides with the release edge is never taken.
  always_comb begin
    last_s    = (state_q == S_SHIFT) && (cnt_q == LAST);
    ready     = (state_q == S_IDLE) || last_s;
    accept_s  = load && ready && arm_q;
    done      = last_s;
    busy      = (state_q == S_SHIFT);
    s_valid   = (state_q == S_SHIFT);
    s_out     = (state_q == S_SHIFT) ? shreg_q[OUT_IDX] : 1'b0;
    shifted_s = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    arm_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_SHIFT;
          shreg_d = d;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (last_s) begin
          // Reload on the last-bit cycle keeps s_valid continuous.
          cnt_d = {CW{1'b0}};
          if (accept_s) begin
            state_d = S_SHIFT;
            shreg_d = d;
          end else begin
            state_d = S_IDLE;
            shreg_d = shifted_s;
          end
        end else begin
          shreg_d = shifted_s;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = {WIDTH{1'b0}};
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
    end
  end

endmodule : piso_shift6

// File: tb/tb_piso_shift6.sv
// Self-checking bench for piso_shift6: queue-based bit-stream reference model
// plus a behavioural loopback receiver.
module tb_piso_shift6;
  import piso_shift6_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] d;
  logic         ready, s_out, s_valid, done, busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference: bits still to appear on s_out, in order; words awaiting loopback.
  bit           exp_q[$];
  logic [W-1:0] sent_q[$];
  bit           arm;
  logic [W-1:0] rx_sr;

  always #5 clk = ~clk;

  piso_shift6 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .d(d),
    .ready(ready), .s_out(s_out), .s_valid(s_valid), .done(done), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check_eq("s_valid", 32'(s_valid), 32'(sz > 0));
    check_eq("s_out",   32'(s_out),   32'((sz > 0) ? exp_q[0] : 1'b0));
    check_eq("done",    32'(done),    32'(sz == 1));
    check_eq("ready",   32'(ready),   32'(sz <= 1));
    check_eq("busy",    32'(busy),    32'(sz > 0));
  endtask

  task automatic step(input bit ld, input logic [W-1:0] dv, input bit sv, input bit so, input bit dn);
    bit acc;
    if (!rst_n) return;
    acc = ld && (exp_q.size() <= 1) && arm;
    if (sv) rx_sr = {so, rx_sr[W-1:1]};
    if (dn) begin
      if (sent_q.size() == 0) check_eq("rx_orphan_done", 32'd1, 32'd0);
      else check_eq("loopback", 32'(rx_sr), 32'(sent_q.pop_front()));
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      for (int i = 0; i < W; i++) exp_q.push_back(dv[i]);
      sent_q.push_back(dv);
    end
    arm = 1'b1;
  endtask

  task automatic cycle(input bit ld, input logic [W-1:0] dv, input bit release_rst = 1'b0);
    bit sv, so, dn;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    load = ld;
    d    = dv;
    #1;
    check_outputs();
    sv = s_valid; so = s_out; dn = done;
    @(posedge clk);
    step(ld, dv, sv, so, dn);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    sent_q.delete();
    arm = 1'b0;
    #1;
    check_outputs();
    cycle(1'b0, W'($urandom));
    cycle(1'b0, W'($urandom));
    // Release with load high: must not be taken at the release edge.
    cycle(1'b1, W'($urandom), 1'b1);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom));
  endtask

  initial begin
    logic [W-1:0] lb_words [3];
    lb_words[0] = 6'h00; lb_words[1] = 6'h3F; lb_words[2] = 6'h2D;
    rst_n = 1'b0; load = 1'b0; d = '0; arm = 1'b0; rx_sr = '0;
    #1;
    check_outputs();
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    cycle(1'b1, 6'h11, 1'b1);
    idle_n(2);

    // Single word, LSB first: 0,0,1,1,0,1.
    cycle(1'b1, 6'b101100);
    idle_n(7);

    // Back-to-back with load held; second word taken on first word's done cycle.
    cycle(1'b1, 6'h2A);
    for (int i = 0; i < W; i++) cycle(1'b1, 6'h15);
    idle_n(8);

    // Load pulsed while busy is ignored.
    cycle(1'b1, 6'h12);
    idle_n(2);
    cycle(1'b1, 6'h3F);
    idle_n(6);

    // Async reset after three bits of a word.
    cycle(1'b1, 6'h2D);
    idle_n(3);
    async_reset();
    idle_n(8);

    // Loopback words.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, lb_words[k]);
      idle_n(6);
    end

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle($urandom_range(0, 2) != 0, W'($urandom));
    end
    idle_n(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_piso_shift6
